// File: rtl/reverb_param_out_pio.sv
// Avalon-MM output PIO for one reverb parameter: host fills a shadow register and commits it.
// The committed value moves to out_port on a sample tick and is then offered to the DSP with valid/ready.
module reverb_param_out_pio #(
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic                  sample_tick,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            state_dbg
);

   // Handshake: a value is transferred to the DSP on every clock edge where
   // out_valid && out_ready; out_port stays constant while out_valid is high.

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      PRESENT = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_SHADOW = 2'd0;
   localparam logic [1:0] ADDR_OUTPUT = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   state_t                  state, state_nxt;
   logic [DATA_WIDTH-1:0]   shadow;
   logic [7:0]              commit_cnt;
   logic                    overrun;
   logic                    wr, ctrl_wr, commit_req, clear_req;
   logic                    load, ack;
   logic [31:0]             rd_mux;
   logic                    unused_bits;

   assign wr         = chipselect && !write_n;
   assign ctrl_wr    = wr && (address == ADDR_CTRL);
   assign commit_req = ctrl_wr && writedata[0];
   assign clear_req  = ctrl_wr && writedata[2];
   assign state_dbg  = state;
   assign unused_bits = ^writedata;

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      ack       = 1'b0;
      case (state)
         IDLE:    if (commit_req) state_nxt = ARMED;
         ARMED:   if (sample_tick) begin
                     state_nxt = PRESENT;
                     load      = 1'b1;
                  end
         PRESENT: if (out_valid && out_ready) begin
                     state_nxt = IDLE;
                     ack       = 1'b1;
                  end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         shadow     <= RESET_VALUE;
         out_port   <= RESET_VALUE;
         out_valid  <= 1'b0;
         commit_cnt <= 8'd0;
         overrun    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (wr && (address == ADDR_SHADOW)) shadow <= writedata[DATA_WIDTH-1:0];
         // out_port samples the pre-edge shadow, so a shadow write in the tick cycle is not carried over
         if (load) begin
            out_port  <= shadow;
            out_valid <= 1'b1;
         end else if (ack) begin
            out_valid <= 1'b0;
         end
         if (ack) commit_cnt <= commit_cnt + 8'd1;
         // A rejected commit wins over a clear landing in the same cycle
         if (commit_req && (state != IDLE)) overrun <= 1'b1;
         else if (clear_req)                overrun <= 1'b0;
      end
   end

   always_comb begin
      rd_mux = 32'd0;
      case (address)
         ADDR_SHADOW: rd_mux = 32'(shadow);
         ADDR_OUTPUT: rd_mux = 32'(out_port);
         ADDR_CTRL:   rd_mux = {16'd0, commit_cnt, 5'd0, overrun, out_valid, (state != IDLE)};
         default:     rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= 32'd0;
      else          readdata <= rd_mux;
   end

endmodule

// File: tb/tb_reverb_param_out_pio.sv
// Bench for reverb_param_out_pio: directed scenarios plus random traffic,
// checked every cycle against a commit-level reference model and a queue of expected transfers.
module tb_reverb_param_out_pio;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic          sample_tick = 1'b0;
   logic [W-1:0]  out_port;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1:0]    state_dbg;

   int checks = 0;
   int failures = 0;

   // reference model: phase 0 = nothing pending, 1 = waiting for tick, 2 = offered to DSP
   logic [W-1:0] m_shadow, m_out;
   logic         m_valid, m_ovr;
   int           m_phase, m_cnt;
   logic [W-1:0] exp_q[$];

   reverb_param_out_pio #(.DATA_WIDTH(W), .RESET_VALUE('0)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .sample_tick(sample_tick), .out_port(out_port), .out_valid(out_valid),
      .out_ready(out_ready), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_shadow = '0; m_out = '0; m_valid = 1'b0; m_ovr = 1'b0;
      m_phase = 0; m_cnt = 0;
      exp_q.delete();
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'd0:    return 32'(m_shadow);
         2'd1:    return 32'(m_out);
         2'd2:    return {16'd0, 8'(m_cnt), 5'd0, m_ovr, m_valid, (m_phase != 0)};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step(input logic cs, input logic wn, input logic [1:0] a,
                             input logic [31:0] d, input logic tk, input logic rdy,
                             input logic [W-1:0] seen_out);
      logic         wr, cmd;
      int           old_phase;
      logic [W-1:0] got;
      wr = cs && !wn;
      cmd = wr && (a == 2'd2);
      old_phase = m_phase;
      if (cmd && d[0] && old_phase != 0) m_ovr = 1'b1;
      else if (cmd && d[2])              m_ovr = 1'b0;
      if (old_phase == 0 && cmd && d[0]) begin
         m_phase = 1;
      end else if (old_phase == 1 && tk) begin
         m_out = m_shadow;
         m_valid = 1'b1;
         m_phase = 2;
         exp_q.push_back(m_shadow);
      end else if (old_phase == 2 && rdy) begin
         check("handshake_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            check("handshake_value", 32'(seen_out), 32'(got));
         end
         m_valid = 1'b0;
         m_cnt = (m_cnt + 1) % 256;
         m_phase = 0;
      end
      if (wr && a == 2'd0) m_shadow = d[W-1:0];
   endtask

   task automatic do_cycle(input logic cs, input logic wn, input logic [1:0] a,
                           input logic [31:0] d, input logic tk, input logic rdy);
      logic [31:0]  exp_rd;
      logic [W-1:0] pre_out;
      @(negedge clk);
      chipselect = cs; write_n = wn; address = a; writedata = d;
      sample_tick = tk; out_ready = rdy;
      pre_out = out_port;
      exp_rd = model_read(a);
      @(posedge clk);
      model_step(cs, wn, a, d, tk, rdy, pre_out);
      #1;
      check("readdata", readdata, exp_rd);
      check("out_port", 32'(out_port), 32'(m_out));
      check("out_valid", 32'(out_valid), 32'(m_valid));
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic tk, input logic rdy);
      do_cycle(1'b1, 1'b0, a, d, tk, rdy);
   endtask

   task automatic idle(input logic [1:0] a, input logic tk, input logic rdy);
      do_cycle(1'b0, 1'b1, a, 32'd0, tk, rdy);
   endtask

   task automatic read_reg(input logic [1:0] a);
      idle(a, 1'b0, 1'b0);
      idle(a, 1'b0, 1'b0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; sample_tick = 1'b0; out_ready = 1'b0;
      reset_n = 1'b0;
      #1;
      check("rst_out_port", 32'(out_port), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_readdata", readdata, 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic commit_once();
      bus_write(2'd2, 32'd1, 1'b0, 1'b0);
      idle(2'd1, 1'b1, 1'b0);
      idle(2'd1, 1'b0, 1'b1);
   endtask

   initial begin
      model_reset();
      // 1: reset values
      #1;
      check("t1_out_port", 32'(out_port), 32'd0);
      check("t1_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 3; a++) begin
         read_reg(2'(a));
         check("t1_read", readdata, 32'd0);
      end

      // 2: basic commit with ready held high
      bus_write(2'd0, 32'h1234, 1'b0, 1'b0);
      bus_write(2'd2, 32'd1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) idle(2'd0, 1'b0, 1'b1);
      idle(2'd0, 1'b1, 1'b1);
      check("t2_out_port", 32'(out_port), 32'h1234);
      check("t2_valid_hi", 32'(out_valid), 32'd1);
      idle(2'd2, 1'b0, 1'b1);
      check("t2_valid_lo", 32'(out_valid), 32'd0);
      read_reg(2'd2);
      check("t2_ctrl", readdata, 32'h100);

      // 3: commit coinciding with tick, shadow write in transfer tick
      bus_write(2'd0, 32'h5555, 1'b0, 1'b0);
      bus_write(2'd2, 32'd1, 1'b1, 1'b0);
      check("t3_no_transfer", 32'(out_valid), 32'd0);
      idle(2'd0, 1'b0, 1'b0);
      bus_write(2'd0, 32'hBEEF, 1'b1, 1'b0);
      check("t3_out_port", 32'(out_port), 32'h5555);
      idle(2'd0, 1'b0, 1'b1);
      read_reg(2'd0);
      check("t3_shadow", readdata, 32'hBEEF);

      // 4: overrun while presenting, then W1C clear
      commit_once();
      bus_write(2'd2, 32'd1, 1'b0, 1'b0);
      idle(2'd1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) idle(2'd1, 1'b0, 1'b0);
      bus_write(2'd2, 32'd1, 1'b0, 1'b0);
      check("t4_valid_held", 32'(out_valid), 32'd1);
      read_reg(2'd2);
      check("t4_ctrl_ovr", readdata & 32'h7, 32'h7);
      bus_write(2'd2, 32'd4, 1'b0, 1'b0);
      read_reg(2'd2);
      check("t4_ctrl_clr", readdata & 32'h7, 32'h3);
      idle(2'd1, 1'b0, 1'b1);

      // 6: reset while armed discards the pending commit
      bus_write(2'd0, 32'h0777, 1'b0, 1'b0);
      bus_write(2'd2, 32'd1, 1'b0, 1'b0);
      apply_reset();
      for (int i = 0; i < 3; i++) idle(2'd2, 1'b1, 1'b1);
      check("t6_no_transfer", 32'(out_valid), 32'd0);
      check("t6_out_port", 32'(out_port), 32'd0);

      // 5: counter wrap and ignored upper write bits
      bus_write(2'd0, 32'hFFFF_ABCD, 1'b0, 1'b0);
      for (int i = 0; i < 255; i++) commit_once();
      read_reg(2'd2);
      check("t5_cnt_ff", readdata, 32'h0000_FF00);
      commit_once();
      read_reg(2'd2);
      check("t5_cnt_wrap", readdata, 32'h0);
      check("t5_out_port", 32'(out_port), 32'hABCD);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  $urandom(), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
